// File: rtl/mips_datapath_fetch_pkg.sv
// Shared types for the MIPS instruction-fetch stage.
// Holds the fetch FSM encoding and small helpers.
package mips_datapath_fetch_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mips_datapath_fetch_fifo.sv
// Circular buffer with push/pop/clear, count and head.
// DEPTH must be a power of two so pointers wrap naturally.
module mips_datapath_fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_i,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i & ~clr_i & (cnt_q != FULL);
  assign do_pop  = pop_i & ~clr_i & (cnt_q != '0);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/mips_datapath_fetch_stage.sv
// Fetch stage: imem request/response with credit flow and redirect flush.
// Define MIPS_DATAPATH_FETCH_STATS_EN for stall/drop counters.
module mips_datapath_fetch_stage
  import mips_datapath_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addrCurr,
  output logic              pcAdvance,
  input  logic              redirect,
  output logic              imemReqValid,
  input  logic              imemReqReady,
  output logic [ADDR_W-1:0] imemReqAddr,
  input  logic              imemRspValid,
  input  logic [31:0]       imemRspData,
  output logic              decValid,
  input  logic              decReady,
  output logic [31:0]       decInstr,
  output logic [ADDR_W-1:0] decPc,
  output logic [ADDR_W-1:0] decPcPlus4
`ifdef MIPS_DATAPATH_FETCH_STATS_EN
  ,
  output logic [31:0]       statStallCycles,
  output logic [31:0]       statFlushDrops
`endif
);

  localparam int CW    = $clog2(DEPTH + 1);
  localparam int ENT_W = INSTR_W + ADDR_W;

  fetch_state_e      state_q, state_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     tag_cnt;
  logic [CW-1:0]     rsp_cnt;
  logic [ADDR_W-1:0] tag_head;
  logic [ENT_W-1:0]  rsp_head;
  logic              credit_ok;
  logic              discarding;
  logic              drop;
  logic              keep;
  logic              dec_pop;

  assign credit_ok  = ({1'b0, inflight_q} + {1'b0, rsp_cnt})
                      < (CW+1)'(DEPTH);
  // rst_n gates the request so it reads 0 the moment reset asserts
  assign imemReqValid = rst_n & (state_q == RUN)
                      & credit_ok & ~redirect;
  assign pcAdvance   = imemReqValid & imemReqReady;
  assign imemReqAddr = addrCurr;

  assign discarding = (discard_q != '0);
  assign drop       = imemRspValid & (redirect | discarding);
  assign keep       = imemRspValid & ~redirect & ~discarding;
  assign dec_pop    = decValid & decReady;

  mips_datapath_fetch_fifo #(
    .W     (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect),
    .push_i  (pcAdvance),
    .data_i  (addrCurr),
    .pop_i   (keep),
    .head_o  (tag_head),
    .count_o (tag_cnt)
  );

  mips_datapath_fetch_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_rsp_q (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (redirect),
    .push_i  (keep),
    .data_i  ({imemRspData, tag_head}),
    .pop_i   (dec_pop),
    .head_o  (rsp_head),
    .count_o (rsp_cnt)
  );

  assign decValid   = (rsp_cnt != '0);
  assign decInstr   = rsp_head[ENT_W-1 -: INSTR_W];
  assign decPc      = rsp_head[ADDR_W-1:0];
  assign decPcPlus4 = decPc + ADDR_W'(4);

  always_comb begin
    inflight_d = inflight_q;
    unique case ({pcAdvance, imemRspValid})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: ;
    endcase
  end

  // No request issues during redirect, so the post-cycle inflight
  // count is exactly what is still owed by memory.
  always_comb begin
    discard_d = discard_q;
    state_d   = state_q;
    if (redirect) begin
      discard_d = inflight_d;
      state_d   = (inflight_d != '0) ? FLUSH : RUN;
    end else begin
      if (drop) discard_d = discard_q - 1'b1;
      if (state_q == FLUSH && discard_d == '0) state_d = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  always @(posedge clk) begin
    if (rst_n && imemRspValid) assert (inflight_q != '0);
    if (rst_n && keep) assert (tag_cnt != '0);
  end

`ifdef MIPS_DATAPATH_FETCH_STATS_EN
  logic [31:0] stall_q;
  logic [31:0] drops_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      drops_q <= '0;
    end else begin
      if (state_q == RUN && !imemReqValid) stall_q <= sat_inc(stall_q);
      if (drop) drops_q <= sat_inc(drops_q);
    end
  end

  assign statStallCycles = stall_q;
  assign statFlushDrops  = drops_q;
`endif

endmodule

// File: tb/tb_mips_datapath_fetch_stage.sv
// Scoreboard bench for the fetch stage with a simple in-order memory.
// Stimulus pushes expected decode PCs; a monitor pops on each handshake.
module tb_mips_datapath_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addrCurr;
  logic        pcAdvance;
  logic        redirect;
  logic        imemReqValid;
  logic        imemReqReady;
  logic [31:0] imemReqAddr;
  logic        imemRspValid;
  logic [31:0] imemRspData;
  logic        decValid;
  logic        decReady;
  logic [31:0] decInstr;
  logic [31:0] decPc;
  logic [31:0] decPcPlus4;
`ifdef MIPS_DATAPATH_FETCH_STATS_EN
  logic [31:0] statStallCycles;
  logic [31:0] statFlushDrops;
`endif

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;

  logic [31:0] exp_q[$];
  logic [31:0] rq[$];
  logic [31:0] pc_m = 32'h0;
  logic [31:0] target = 32'h0;
  logic        mem_stall = 1'b0;
  logic        s_acc = 1'b0;
  logic        s_rsp = 1'b0;
  logic        s_redir = 1'b0;
  logic [31:0] s_addr = 32'h0;

  mips_datapath_fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addrCurr     (addrCurr),
    .pcAdvance    (pcAdvance),
    .redirect     (redirect),
    .imemReqValid (imemReqValid),
    .imemReqReady (imemReqReady),
    .imemReqAddr  (imemReqAddr),
    .imemRspValid (imemRspValid),
    .imemRspData  (imemRspData),
    .decValid     (decValid),
    .decReady     (decReady),
    .decInstr     (decInstr),
    .decPc        (decPc),
    .decPcPlus4   (decPcPlus4)
`ifdef MIPS_DATAPATH_FETCH_STATS_EN
    ,
    .statStallCycles (statStallCycles),
    .statFlushDrops  (statFlushDrops)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory + PC model: acts on handshakes sampled just before the edge
  always begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      rq.delete();
      pc_m = 32'h0;
    end else begin
      if (s_redir) pc_m = target;
      else if (s_acc) pc_m = pc_m + 32'd4;
      if (s_rsp && rq.size() > 0) void'(rq.pop_front());
      if (s_acc) rq.push_back(s_addr);
    end
    addrCurr = pc_m;
    if (rst_n && !mem_stall && rq.size() > 0) begin
      imemRspValid = 1'b1;
      imemRspData  = ~rq[0];
    end else begin
      imemRspValid = 1'b0;
      imemRspData  = 32'h0;
    end
  end

  always begin
    @(negedge clk);
    #4;
    s_acc   = rst_n && pcAdvance;
    s_rsp   = rst_n && imemRspValid;
    s_redir = rst_n && redirect;
    s_addr  = imemReqAddr;
    if (s_acc) acc_cnt++;
  end

  always begin : mon
    logic [31:0] e;
    @(negedge clk);
    #4;
    if (rst_n && decValid && decReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got pc %h expected none", decPc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", decPc, e);
        chk("sb_instr", decInstr, ~e);
        chk("sb_pc4", decPcPlus4, e + 32'd4);
      end
    end
  end

  task automatic fetch_n(input int n);
    int tgt = acc_cnt + n;
    int c = 0;
    imemReqReady = 1'b1;
    while (acc_cnt < tgt && c < 200) begin
      @(negedge clk);
      c++;
    end
    imemReqReady = 1'b0;
    chk("fetch_count", 32'(acc_cnt), 32'(tgt));
  endtask

  task automatic drain();
    int c = 0;
    while ((rq.size() != 0 || decValid || exp_q.size() != 0)
           && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic redir(input logic [31:0] t);
    target   = t;
    redirect = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n        = 1'b0;
    redirect     = 1'b0;
    imemReqReady = 1'b1;
    decReady     = 1'b0;
    addrCurr     = 32'h0;
    imemRspValid = 1'b0;
    imemRspData  = 32'h0;
    repeat (2) @(negedge clk);
    #3;
    chk("rst_req", 32'(imemReqValid), 32'd0);
    chk("rst_adv", 32'(pcAdvance), 32'd0);
    chk("rst_dec", 32'(decValid), 32'd0);
`ifdef MIPS_DATAPATH_FETCH_STATS_EN
    chk("rst_stall", statStallCycles, 32'd0);
    chk("rst_drops", statFlushDrops, 32'd0);
`endif
    @(negedge clk);
    imemReqReady = 1'b0;
    rst_n = 1'b1;

    // streaming
    decReady = 1'b1;
    push_seq(32'h0, 8);
    fetch_n(8);
    drain();

    // decode backpressure
    redir(32'h100);
    decReady = 1'b0;
    base = acc_cnt;
    imemReqReady = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    chk("bp_accepts", 32'(acc_cnt - base), 32'd2);
    chk("bp_req", 32'(imemReqValid), 32'd0);
    chk("bp_adv", 32'(pcAdvance), 32'd0);
    chk("bp_head", decPc, 32'h100);
    @(negedge clk);
    push_seq(32'h100, 6);
    decReady = 1'b1;
    fetch_n(4);
    drain();

    // flush with two requests outstanding
    redir(32'h300);
    mem_stall = 1'b1;
    fetch_n(2);
    #3;
    chk("credit_stall", 32'(imemReqValid), 32'd0);
    @(negedge clk);
    redir(32'h1000);
    #3;
    chk("flush_block", 32'(imemReqValid), 32'd0);
    @(negedge clk);
    mem_stall = 1'b0;
    push_seq(32'h1000, 3);
    fetch_n(3);
    drain();
`ifdef MIPS_DATAPATH_FETCH_STATS_EN
    chk("stat_drops2", statFlushDrops, 32'd2);
`endif

    // redirect coincident with response and decode pop
    redir(32'h400);
    decReady  = 1'b0;
    fetch_n(1);
    repeat (2) @(negedge clk);
    #3;
    chk("held_head", decPc, 32'h400);
    @(negedge clk);
    mem_stall = 1'b1;
    fetch_n(1);
    exp_q.push_back(32'h400);
    mem_stall = 1'b0;
    decReady  = 1'b1;
    target    = 32'h500;
    redirect  = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    #3;
    chk("redir_dec_empty", 32'(decValid), 32'd0);
    chk("redir_run", 32'(imemReqValid), 32'd1);
    @(negedge clk);
    push_seq(32'h500, 2);
    fetch_n(2);
    drain();
`ifdef MIPS_DATAPATH_FETCH_STATS_EN
    chk("stat_drops3", statFlushDrops, 32'd3);
    chk("stat_stall_nz", 32'(statStallCycles != 0), 32'd1);
`endif

    // imemReqReady toggling
    redir(32'h2000);
    decReady = 1'b1;
    push_seq(32'h2000, 6);
    base = acc_cnt;
    for (int i = 0; i < 12; i++) begin
      imemReqReady = (i % 2 == 0);
      #3;
      chk("ack_toggle", 32'(pcAdvance), 32'(imemReqReady));
      @(negedge clk);
    end
    imemReqReady = 1'b0;
    chk("toggle_accepts", 32'(acc_cnt - base), 32'd6);
    drain();

    // async reset mid-stream
    redir(32'h3000);
    decReady = 1'b0;
    fetch_n(2);
    imemReqReady = 1'b1;
    #1;
    chk("pre_rst_dec", 32'(decValid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_req", 32'(imemReqValid), 32'd0);
    chk("async_adv", 32'(pcAdvance), 32'd0);
    chk("async_dec", 32'(decValid), 32'd0);
`ifdef MIPS_DATAPATH_FETCH_STATS_EN
    chk("async_drops", statFlushDrops, 32'd0);
`endif
    @(negedge clk);
    imemReqReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    decReady = 1'b1;
    push_seq(32'h0, 3);
    fetch_n(3);
    drain();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
